// File: rtl/audio_pkg.sv
// Shared note codes, FSM state type and pitch table for the audio output path.
// half_period() is a constant function meant to be evaluated at elaboration.
package audio_pkg;

    localparam logic [3:0] NOTE_A    = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_C    = 4'd2;
    localparam logic [3:0] NOTE_D    = 4'd3;
    localparam logic [3:0] NOTE_E    = 4'd4;
    localparam logic [3:0] NOTE_F    = 4'd5;
    localparam logic [3:0] NOTE_G    = 4'd6;
    localparam logic [3:0] NOTE_REST = 4'd7;
    localparam logic [3:0] NOTE_END  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUTE = 2'd1,
        ST_TONE = 2'd2
    } tone_state_t;

    function automatic int note_freq_hz(input logic [3:0] code);
        note_freq_hz = 0;
        case (code)
            NOTE_A:  note_freq_hz = 440;
            NOTE_B:  note_freq_hz = 494;
            NOTE_C:  note_freq_hz = 523;
            NOTE_D:  note_freq_hz = 587;
            NOTE_E:  note_freq_hz = 659;
            NOTE_F:  note_freq_hz = 698;
            NOTE_G:  note_freq_hz = 784;
            default: note_freq_hz = 0;
        endcase
    endfunction

    function automatic int half_period(input logic [3:0] code, input int clk_hz);
        int f;
        f = note_freq_hz(code);
        half_period = (f == 0) ? 0 : clk_hz / (2 * f);
    endfunction

    // Codes above REST (END and the unused 9-15) all mean silence.
    function automatic logic [3:0] map_code(input logic [3:0] code);
        map_code = (code > NOTE_REST) ? NOTE_REST : code;
    endfunction

    function automatic logic is_tone(input logic [3:0] code);
        is_tone = (code < NOTE_REST);
    endfunction

endpackage

// File: rtl/note_select_filter.sv
// Debounces the sequencer note code: a code is accepted only after it has
// been held unchanged for STABLE_CYCLES cycles, which hides load/increment glitches.
module note_select_filter
    import audio_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] noteSelect,
    output logic [3:0] accepted
);

    localparam int                  CNT_BITS = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(STABLE_CYCLES - 1);

    logic [3:0]          r_cand;
    logic [CNT_BITS-1:0] r_cnt;
    logic [3:0]          r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= NOTE_REST;
            r_cnt  <= '0;
            r_acc  <= NOTE_REST;
        end else if (clear) begin
            r_cand <= NOTE_REST;
            r_cnt  <= '0;
            r_acc  <= NOTE_REST;
        end else if (noteSelect != r_cand) begin
            r_cand <= noteSelect;
            r_cnt  <= '0;
        end else begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Count saturates, so a held code keeps being offered until it lands.
            if ((r_cnt == CNT_MAX) && (map_code(r_cand) != r_acc)) begin
                r_acc <= map_code(r_cand);
            end
        end
    end

    assign accepted = r_acc;

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator driven by the filtered note code. Pitch changes
// and stops are applied only at the end of a full period (end of the low phase).
module note_tone_gen
    import audio_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] noteSelect,
    output logic       audio_out,
    output logic       audio_sd,
    output logic       note_active,
    output logic [3:0] current_note,
    output logic       tone_tick,
    output logic [1:0] o_dbg_state
);

    // Counter runs reload..0, so loading half_period-1 gives half_period cycles per phase.
    localparam logic [CNT_W-1:0] RELOAD_A = CNT_W'(half_period(NOTE_A, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_B = CNT_W'(half_period(NOTE_B, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(half_period(NOTE_C, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_D = CNT_W'(half_period(NOTE_D, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_E = CNT_W'(half_period(NOTE_E, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_F = CNT_W'(half_period(NOTE_F, CLK_HZ) - 1);
    localparam logic [CNT_W-1:0] RELOAD_G = CNT_W'(half_period(NOTE_G, CLK_HZ) - 1);

    function automatic logic [CNT_W-1:0] reload_for(input logic [3:0] code);
        reload_for = '0;
        case (code)
            NOTE_A:  reload_for = RELOAD_A;
            NOTE_B:  reload_for = RELOAD_B;
            NOTE_C:  reload_for = RELOAD_C;
            NOTE_D:  reload_for = RELOAD_D;
            NOTE_E:  reload_for = RELOAD_E;
            NOTE_F:  reload_for = RELOAD_F;
            NOTE_G:  reload_for = RELOAD_G;
            default: reload_for = '0;
        endcase
    endfunction

    tone_state_t      r_state;
    tone_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_tick;
    logic [3:0]       r_note;
    logic [3:0]       w_accepted;
    logic             w_period_end;

    note_select_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .clear     (!enable),
        .noteSelect(noteSelect),
        .accepted  (w_accepted)
    );

    assign w_period_end = (r_state == ST_TONE) && (r_cnt == '0) && !r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_MUTE;
                ST_MUTE: begin
                    if (is_tone(w_accepted)) begin
                        w_next_state = ST_TONE;
                    end
                end
                ST_TONE: begin
                    if (w_period_end && !is_tone(w_accepted)) begin
                        w_next_state = ST_MUTE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        audio_sd     = 1'b0;
        note_active  = 1'b0;
        current_note = NOTE_REST;
        case (r_state)
            ST_MUTE: audio_sd = 1'b1;
            ST_TONE: begin
                audio_sd     = 1'b1;
                note_active  = 1'b1;
                current_note = r_note;
            end
            default: ;
        endcase
    end

    assign audio_out   = r_level;
    assign tone_tick   = r_tick;
    assign o_dbg_state = r_state;

    // Disable wins over any boundary or acceptance in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
            r_note  <= NOTE_REST;
        end else if (!enable) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
            r_note  <= NOTE_REST;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_MUTE: begin
                    if (is_tone(w_accepted)) begin
                        r_level <= 1'b1;
                        r_tick  <= 1'b1;
                        r_note  <= w_accepted;
                        r_cnt   <= reload_for(w_accepted);
                    end
                end
                ST_TONE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_level) begin
                        r_level <= 1'b0;
                        r_cnt   <= reload_for(r_note);
                    end else if (is_tone(w_accepted)) begin
                        r_level <= 1'b1;
                        r_tick  <= 1'b1;
                        r_note  <= w_accepted;
                        r_cnt   <= reload_for(w_accepted);
                    end else begin
                        r_level <= 1'b0;
                        r_note  <= NOTE_REST;
                    end
                end
                default: r_level <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Consumer end of the sequencer's 4-bit note-select interface. Converts the note code into a square-wave drive for the board audio amplifier.
- Filters the short mute glitches the sequencer emits between notes (load/increment cycles).
- Changes pitch only on whole-period boundaries.
- Sits between the audio sequencer and the speaker output pins.

Parameters:
- CLK_HZ, 100000000: system clock frequency. Half-period for note f = floor(CLK_HZ / (2*f)).
- STABLE_CYCLES, 16: cycles a new code must hold unchanged before it is accepted.
- CNT_W, 17: half-period counter width. Must hold the largest half-period (A, 113636 at 100 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block enable; low forces silence
- noteSelect  in  4  note code: 0=A 1=B 2=C 3=D 4=E 5=F 6=G 7=rest 8=end; 9-15 treated as rest
- audio_out  out  1  square-wave drive to amplifier
- audio_sd  out  1  amplifier shutdown-bar; 1 = amplifier on
- note_active  out  1  1 while a tone (codes 0-6) is being generated
- current_note  out  4  code currently sounding; 7 when silent
- tone_tick  out  1  one-cycle pulse on every 0->1 edge of audio_out

Behaviour:
- Reset (asynchronous): all outputs 0 except current_note=7; filter candidate=7; stable count=0; state=IDLE.
- Frequencies (Hz): A440, B494, C523, D587, E659, F698, G784. Half-periods at 100 MHz:
  - A 113636, B 101214, C 95602, D 85178
  - E 75872, F 71633, G 63775
- Input filter:
  - If noteSelect != candidate: candidate<=noteSelect, count<=0.
  - Else the count saturates at STABLE_CYCLES-1.
  - At count==STABLE_CYCLES-1 with candidate != accepted: accepted<=candidate (mapped, 8-15 -> 7). The new code therefore lands STABLE_CYCLES cycles after noteSelect settles.
  - Pulses shorter than STABLE_CYCLES are never accepted.
- State IDLE (enable=0):
  - audio_out=0, audio_sd=0, note_active=0, current_note=7.
  - Filter held with candidate=7, count=0.
  - Enable rising -> MUTE next cycle.
- State MUTE:
  - audio_out=0, audio_sd=1, note_active=0.
  - accepted in 0-6 -> TONE next cycle: audio_out<=1, counter loaded with that half-period, tone_tick=1, current_note<=accepted.
- State TONE:
  - Counter decrements each cycle. At 0, audio_out toggles and the counter reloads.
  - accepted changes take effect only at a 1->0 toggle (end of a full period):
    - accepted in 0-6 and different -> next high phase uses the new half-period; current_note updates at that 0->1 edge.
    - accepted = 7 -> at the 1->0 boundary go to MUTE; current_note<=7; audio_out stays 0.
- tone_tick asserts exactly in the cycle audio_out goes 0->1.
- enable=0 in any state -> IDLE next cycle, aborting mid-period. This overrides a simultaneous boundary or acceptance.
- Reset mid-tone: immediate silence, outputs at reset values.
- Multiple acceptances within one period: only the latest accepted code is applied at the boundary.

Decomposition:
- Shared package audio_pkg: note code constants (NOTE_A..NOTE_G=0-6, NOTE_REST=7, NOTE_END=8), frequency table, and a constant function half_period(code, CLK_HZ).
- Sub-module note_select_filter: candidate/count/accepted logic. Ports: clk, reset, clear, noteSelect, accepted[3:0].
- Top level holds the IDLE/MUTE/TONE FSM and the half-period counter.

Test Plan (CLK_HZ=88000, STABLE_CYCLES=16 -> half-periods A=100, C=84, E=66, G=56):
1. Reset released, enable=1, noteSelect=0 held -> acceptance 16 cycles after settling; audio_out rises the next cycle with tone_tick=1, then toggles every 100 cycles; current_note=0, note_active=1.
2. During A, noteSelect -> 7 for 2 cycles, then -> 6 -> the 2-cycle rest is never accepted; after the G code is stable 16 cycles, the current A period completes; the next high phase lasts 56 cycles; current_note=6 at that edge.
3. Tone E, noteSelect=7 held -> E finishes its full period (66 high + 66 low); audio_out stays 0, note_active=0, current_note=7, audio_sd=1.
4. Codes 8 and 12 each held 40 cycles -> treated as rest; no tone_tick, current_note=7.
5. enable dropped mid-high-phase of C -> next cycle audio_out=0, audio_sd=0, current_note=7; re-enable with noteSelect=2 -> tone restarts 16 cycles after the code is stable, with a full 84-cycle high phase.
6. reset asserted mid-tone (asynchronous, between clock edges) -> outputs go to reset values immediately; after release with enable=1 and noteSelect=0 held, scenario 1 timing repeats exactly.
